mastermind_solver_p: RTL
========================

Name: mastermind_solver_p

Overview:
- Parametrised successor to the fixed 4-digit bulls-only solver.
- Searches a secret code of DIGITS positions, each holding a digit in 0..MAX_VAL, one position at a time. Uses only the bulls count returned by the scoring block.
- Submits each guess to the frame writer through the write_frame/frame_written handshake. Supports restart, reports failure, and exposes an index/state view for the display.

Parameters:
- DIGITS, 4, number of code positions (2..8).
- DIGIT_W, 4, bits per digit.
- MAX_VAL, 9, largest legal digit value (must be < 2**DIGIT_W).
- SETTLE_CYCLES, 2, wait cycles after frame_written before bulls is sampled (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; restarts the search from DONE or FAIL, ignored elsewhere.
- bulls  in  $clog2(DIGITS+1)  score of the last displayed guess.
- frame_written  in  1  frame writer has latched the guess.
- guess  out  DIGITS*DIGIT_W  current guess; digit i at [i*DIGIT_W +: DIGIT_W].
- write_frame  out  1  request to the frame writer.
- cur_index  out  $clog2(DIGITS)  position being searched.
- done  out  1  secret found; guess holds it.
- fail  out  1  search exhausted without DIGITS bulls.

Behaviour:
- Reset (async assert, release synchronous to clk): all outputs 0, all digit registers 0, old_bulls 0, state SUBMIT_BASE.
- Reset asserted mid-operation aborts immediately; no partial handshake survives.
- State SUBMIT_BASE:
  - write_frame=1 with guess all zeros; hold until frame_written=1.
  - Cycle after frame_written=1 seen: write_frame=0, next state SETTLE.
  - Baseline flag is set.
- State SETTLE: count SETTLE_CYCLES clocks, then go to EVAL.
- State EVAL: sample bulls as b.
  - If b==DIGITS: go to DONE, done=1 next cycle. This has priority over every other rule.
  - Baseline flag set: old_bulls<=b, clear flag, go to STEP.
  - b>old_bulls: new digit value is correct; old_bulls<=b; cur_index++; go to STEP.
  - b<old_bulls: previous value was correct; digit[cur_index]--; old_bulls unchanged; cur_index++; go to STEP without resubmitting.
  - b==old_bulls: stay on the same index; go to STEP.
- State STEP:
  - If cur_index wrapped past DIGITS-1 (tracked with an extra carry bit): go to FAIL.
  - Else if digit[cur_index]==MAX_VAL: go to FAIL. The value space is exhausted.
  - Else digit[cur_index]++ and go to SUBMIT.
- State SUBMIT: same handshake as SUBMIT_BASE; next state SETTLE.
- State DONE / FAIL:
  - Outputs held; write_frame=0.
  - start=1 clears digits, old_bulls, cur_index, done and fail; next state SUBMIT_BASE.
- Handshake rules:
  - write_frame rises only in SUBMIT/SUBMIT_BASE.
  - guess is stable for the whole time write_frame=1 and until the next STEP.
  - frame_written already high on entry is still honoured: write_frame asserts for one cycle, then drops.
  - frame_written outside SUBMIT states is ignored.
- Arithmetic:
  - Digits are unsigned DIGIT_W.
  - Increment never exceeds MAX_VAL, because the STEP guard fires first.
  - Decrement is only reached after at least one increment at that index, so it never underflows.
- Bulls are compared unsigned at full bulls width.
- Latency per guess: 1 (STEP) + handshake (≥2) + SETTLE_CYCLES + 1 (EVAL).

Optional Feature:
- Macro: SOLVER_GUESS_COUNT_EN.
- Defined:
  - Adds output guess_count [15:0]: counts completed submissions, including the baseline; saturates at 16'hFFFF; cleared by reset and by start.
  - Adds parameter MAX_GUESSES (default 64). In STEP, guess_count==MAX_GUESSES forces FAIL.
- Undefined: no port, no counter, no guess limit.

Test Plan:
- DIGITS=4, MAX_VAL=9, secret 4,7,0,9; writer acks 1 cycle after write_frame:
  - Required: 22 submissions (baseline bulls=1), final guess 4,7,0,9, done=1, fail=0.
  - With SOLVER_GUESS_COUNT_EN: guess_count==22.
- Secret 0,0,0,0 -> baseline bulls=4 -> done=1 after the first EVAL, exactly 1 submission.
- Secret 0,5,5,5:
  - Digit0 increment to 1 drops bulls 1->0 -> digit0 restored to 0, old_bulls stays 1.
  - Search completes with guess 0,5,5,5.
- Faulty scorer holding bulls=0 forever -> digit0 reaches 9 -> fail=1, write_frame=0, outputs stable; then start pulse -> guess all zeros and baseline resubmitted.
- Writer stalls frame_written for 20 cycles -> write_frame held high and guess unchanged for all 20 cycles; no bulls sampling before SETTLE_CYCLES=2 elapses.
- Reset asserted asynchronously while write_frame=1 in SUBMIT -> write_frame, done, fail and guess go to 0 without waiting for a clk edge; after release the search restarts from the baseline.

Source files
------------

// File: rtl/mastermind_solver_p.sv
// Position-by-position Mastermind code search driven only by the bulls score.
// Optional guess counter and guess limit are enabled with `define SOLVER_GUESS_COUNT_EN.
module mastermind_solver_p #(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter int MAX_VAL       = 9,
    parameter int SETTLE_CYCLES = 2
`ifdef SOLVER_GUESS_COUNT_EN
    ,
    parameter int MAX_GUESSES   = 64
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(DIGITS+1)-1:0]   bulls,
    input  logic                          frame_written,
    output logic [DIGITS*DIGIT_W-1:0]     guess,
    output logic                          write_frame,
    output logic [$clog2(DIGITS)-1:0]     cur_index,
    output logic                          done,
    output logic                          fail,
    output logic [2:0]                    state_dbg
`ifdef SOLVER_GUESS_COUNT_EN
    ,
    output logic [15:0]                   guess_count
`endif
);

    localparam int IW = $clog2(DIGITS);
    localparam int BW = $clog2(DIGITS + 1);
    localparam int GW = DIGITS * DIGIT_W;

    localparam logic [IW:0]         IDX_END     = (IW+1)'(DIGITS);
    localparam logic [BW-1:0]       BULLS_ALL   = BW'(DIGITS);
    localparam logic [DIGIT_W-1:0]  DIG_MAX     = DIGIT_W'(MAX_VAL);
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_SUBMIT_BASE = 3'd0,
        S_SETTLE      = 3'd1,
        S_EVAL        = 3'd2,
        S_STEP        = 3'd3,
        S_SUBMIT      = 3'd4,
        S_DONE        = 3'd5,
        S_FAIL        = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       dig_q, dig_d;
    logic [IW:0]         idx_q, idx_d;
    logic [BW-1:0]       old_q, old_d;
    logic                base_q, base_d;
    logic                wf_q, wf_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IW-1:0]       idx_lo;
    logic [DIGIT_W-1:0]  cur_dig;
`ifdef SOLVER_GUESS_COUNT_EN
    logic [15:0]         gc_q, gc_d;
`endif

    assign idx_lo  = idx_q[IW-1:0];
    assign cur_dig = dig_q[idx_lo*DIGIT_W +: DIGIT_W];

    // Handshake: write_frame is a registered request held with a frozen guess;
    // the transfer completes on the first clock where write_frame and frame_written are both high.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        idx_d   = idx_q;
        old_d   = old_q;
        base_d  = base_q;
        wf_d    = 1'b0;
        done_d  = done_q;
        fail_d  = fail_q;
        cnt_d   = 4'd0;
`ifdef SOLVER_GUESS_COUNT_EN
        gc_d    = gc_q;
`endif
        case (state_q)
            S_SUBMIT_BASE, S_SUBMIT: begin
                if (state_q == S_SUBMIT_BASE) base_d = 1'b1;
                if (wf_q && frame_written) begin
                    state_d = S_SETTLE;
`ifdef SOLVER_GUESS_COUNT_EN
                    if (gc_q != 16'hFFFF) gc_d = gc_q + 16'd1;
`endif
                end else begin
                    wf_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_EVAL;
                else                      cnt_d   = cnt_q + 4'd1;
            end
            S_EVAL: begin
                state_d = S_STEP;
                if (bulls == BULLS_ALL) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (base_q) begin
                    old_d  = bulls;
                    base_d = 1'b0;
                end else if (bulls > old_q) begin
                    old_d = bulls;
                    idx_d = idx_q + 1'b1;
                end else if (bulls < old_q) begin
                    // The previous value at this index was the bull; step back and move on.
                    dig_d[idx_lo*DIGIT_W +: DIGIT_W] = cur_dig - 1'b1;
                    idx_d = idx_q + 1'b1;
                end
            end
            S_STEP: begin
                if (idx_q >= IDX_END) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
`ifdef SOLVER_GUESS_COUNT_EN
                end else if (gc_q == 16'(MAX_GUESSES)) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
`endif
                end else if (cur_dig == DIG_MAX) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    dig_d[idx_lo*DIGIT_W +: DIGIT_W] = cur_dig + 1'b1;
                    state_d = S_SUBMIT;
                end
            end
            S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_SUBMIT_BASE;
                    dig_d   = '0;
                    idx_d   = '0;
                    old_d   = '0;
                    base_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
`ifdef SOLVER_GUESS_COUNT_EN
                    gc_d    = 16'd0;
`endif
                end
            end
            default: state_d = S_SUBMIT_BASE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_SUBMIT_BASE;
            dig_q   <= '0;
            idx_q   <= '0;
            old_q   <= '0;
            base_q  <= 1'b1;
            wf_q    <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            cnt_q   <= 4'd0;
`ifdef SOLVER_GUESS_COUNT_EN
            gc_q    <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            idx_q   <= idx_d;
            old_q   <= old_d;
            base_q  <= base_d;
            wf_q    <= wf_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
`ifdef SOLVER_GUESS_COUNT_EN
            gc_q    <= gc_d;
`endif
        end
    end

    assign guess       = dig_q;
    assign write_frame = wf_q;
    assign cur_index   = idx_lo;
    assign done        = done_q;
    assign fail        = fail_q;
    assign state_dbg   = state_q;
`ifdef SOLVER_GUESS_COUNT_EN
    assign guess_count = gc_q;
`endif

endmodule
